// File: rtl/somador_serial_ctrl_if.sv
// rtl/somador_serial_ctrl_if.sv - start/done handshake and operand/result bus for the serial adder
// The master drives the request and operands; the slave returns status and results.
interface somador_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, ovf
  );
endinterface

// File: rtl/somador_serial_ctrl.sv
// rtl/somador_serial_ctrl.sv - bit-serial add/subtract controller around one full-adder cell
// Operands are shifted LSB first through a single cell over WIDTH cycles.
module somador_completo_case (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  always_comb begin
    S    = 1'b0;
    Cout = 1'b0;
    case ({A, B, Cin})
      3'b000: begin S = 1'b0; Cout = 1'b0; end
      3'b001: begin S = 1'b1; Cout = 1'b0; end
      3'b010: begin S = 1'b1; Cout = 1'b0; end
      3'b011: begin S = 1'b0; Cout = 1'b1; end
      3'b100: begin S = 1'b1; Cout = 1'b0; end
      3'b101: begin S = 1'b0; Cout = 1'b1; end
      3'b110: begin S = 1'b0; Cout = 1'b1; end
      3'b111: begin S = 1'b1; Cout = 1'b1; end
      default: begin S = 1'b0; Cout = 1'b0; end
    endcase
  end
endmodule

module somador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  somador_serial_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_s;
  logic cell_cout;

  somador_completo_case u_cell (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (cell_s),
    .Cout (cell_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1, so the inverted operand and forced carry go in here.
          a_sh_d  = bus.A;
          b_sh_d  = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub ? 1'b1 : bus.Cin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        carry_d = cell_cout;
        s_sh_d  = {cell_s, s_sh_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this last step.
          s_d     = s_sh_d;
          cout_d  = cell_cout;
          ovf_d   = carry_q ^ cell_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == CALC) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
